wk_schedule: RTL
================

// Module: wk_schedule
// PURPOSE
//  SHA-256 message-schedule stage; sits directly upstream of hash_update.
//  - Captures one 512-bit padded block.
//  - Streams one {W[t], K[t]} pair per clock for t = 0..WK_LENGTH-1, with index and a last-word flag.
//  - W[t] for t>=16 comes from a 16-entry circular word buffer, so no 64-word array is stored.
// PARAMETERS
//  WK_LENGTH  64  rounds per block; only 64 is supported (K table depth). IW = $clog2(WK_LENGTH).
// PORTS
//  clock              in   1    single clock, rising edge
//  reset_n            in   1    asynchronous, active-low reset
//  enable             in   1    start/hold: rise in IDLE starts a block; low aborts
//  message_block      in   512  padded block; W0 = [511:480] ... W15 = [31:0]
//  cur_w              out  32   W[t]
//  cur_k              out  32   K[t]
//  wk_vector_index    out  IW   t of the pair currently presented
//  wk_valid           out  1    cur_w/cur_k/index are meaningful this cycle
//  wk_index_complete  out  1    high while t = WK_LENGTH-1 is presented, and after that
// BEHAVIOUR
//  Reset (reset_n = 0, any time, asynchronous)
//   - state = IDLE; all outputs 0; buffer contents don't-care.
//  State machine: IDLE -> LOAD -> RUN -> DONE
//   - IDLE: outputs 0. enable = 1 -> LOAD.
//   - LOAD (1 cycle): buf[i] <= message_block word i, i = 0..15; counter t <= 0 -> RUN.
//   - RUN: registered outputs each cycle.
//     - wk_valid = 1, index = t, cur_k = K[t].
//     - t < 16: cur_w = buf[t].
//     - t >= 16: cur_w = s1(buf[(t-2)%16]) + buf[(t-7)%16] + s0(buf[(t-15)%16]) + buf[t%16], mod 2^32.
//       The same value is written to buf[t%16] in the same cycle.
//     - s0(x) = ROTR7 ^ ROTR18 ^ SHR3; s1(x) = ROTR17 ^ ROTR19 ^ SHR10.
//     - t = 63 presented: wk_index_complete = 1 -> DONE.
//   - DONE: wk_valid = 0; wk_index_complete held 1; index held 63; cur_w/cur_k held.
//     enable = 0 -> IDLE, with wk_index_complete cleared on that edge.
//  Latency
//   - enable sampled high at edge E0.
//   - Pair t is on the outputs from edge E0 + 2 + t.
//   - Last pair appears at E0 + 65. Throughput: 1 pair/cycle; block period = 66 cycles + idle.
//  Boundary cases
//   - enable low in LOAD or RUN: abort; next edge -> IDLE, all outputs 0.
//   - enable held high in DONE: no restart; stays DONE.
//   - A new block requires enable low for at least 1 cycle.
//   - message_block is sampled only in LOAD; later changes are ignored.
//   - Circular index wraps 15 -> 0 via t[3:0]. Counter never exceeds 63.
//   - All adds are 32-bit, carries discarded.
// STRUCTURE
//  sha256_defs.vh
//   - the 64 K constants; the s0/s1 rotate amounts; state encodings (IDLE/LOAD/RUN/DONE, 2 bits).
//  Sub-module sha256_k_rom (combinational, input [5:0] index, output [31:0] k).
//   - Registered into cur_k inside wk_schedule.
//  Inside wk_schedule: FSM, 6-bit counter, 16x32 buffer, s0/s1 expansion logic.
// TESTING
//  1. "abc" block (W0 = 0x61626380, W1..14 = 0, W15 = 0x00000018), enable pulse held.
//     -> index 0: W = 0x61626380, K = 0x428a2f98; W16 = 0x61626380; W17 = 0x000f0000;
//        index 63: K = 0xc67178f2 with wk_index_complete = 1. All 64 W match a C model.
//  2. Timing: enable rises at edge N -> wk_valid first high after edge N+2.
//     -> 64 consecutive valid cycles; complete first high after edge N+65.
//  3. Abort: enable dropped while index = 20.
//     -> next edge: IDLE, outputs 0. A restart with a new block streams that block from W0.
//  4. Async reset: reset_n pulsed low mid-cycle while index = 40.
//     -> outputs 0 immediately, without waiting for a clock edge; after release, idle until enable.
//  5. Back-to-back: two random blocks, enable low for 1 cycle between them.
//     -> both streams match the model; wk_index_complete clears when enable drops.
//  6. DONE hold: enable kept high 10 cycles after completion.
//     -> complete stays 1, wk_valid 0, index 63, no restart.

Source files
------------

// File: rtl/wk_schedule_pkg.sv
// Shared definitions for the SHA-256 message-schedule stage: FSM states,
// sigma rotate amounts, the round-constant table and the sigma helpers.
package wk_schedule_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam int unsigned S0_R1 = 7;
  localparam int unsigned S0_R2 = 18;
  localparam int unsigned S0_SH = 3;
  localparam int unsigned S1_R1 = 17;
  localparam int unsigned S1_R2 = 19;
  localparam int unsigned S1_SH = 10;

  localparam logic [31:0] K_TABLE [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] sig0(input logic [31:0] x);
    return rotr(x, S0_R1) ^ rotr(x, S0_R2) ^ (x >> S0_SH);
  endfunction

  function automatic logic [31:0] sig1(input logic [31:0] x);
    return rotr(x, S1_R1) ^ rotr(x, S1_R2) ^ (x >> S1_SH);
  endfunction

endpackage

// File: rtl/wk_schedule_k_rom.sv
// Combinational SHA-256 round-constant lookup; registered by the caller.
module sha256_k_rom
  import wk_schedule_pkg::*;
(
  input  logic [5:0]  index,
  output logic [31:0] k
);

  assign k = K_TABLE[index];

endmodule

// File: rtl/wk_schedule.sv
// SHA-256 message schedule: captures a 512-bit block and streams one
// registered {W[t], K[t]} pair per clock using a 16-word circular buffer.
module wk_schedule
  import wk_schedule_pkg::*;
#(
  parameter  int unsigned WK_LENGTH = 64,
  localparam int unsigned IW        = $clog2(WK_LENGTH)
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          enable,
  input  logic [511:0]  message_block,
  output logic [31:0]   cur_w,
  output logic [31:0]   cur_k,
  output logic [IW-1:0] wk_vector_index,
  output logic          wk_valid,
  output logic          wk_index_complete
);

  state_t        state, state_next;
  logic [IW-1:0] t;
  logic [31:0]   wbuf [16];
  logic [31:0]   w_new;
  logic [31:0]   k_t;
  logic          last;
  logic [3:0]    i0, i2, i7, i15;

  sha256_k_rom u_k_rom (
    .index (t),
    .k     (k_t)
  );

  assign last = (t == IW'(WK_LENGTH - 1));
  assign i0   = t[3:0];
  assign i2   = t[3:0] - 4'd2;
  assign i7   = t[3:0] - 4'd7;
  assign i15  = t[3:0] + 4'd1;

  always_comb begin
    w_new = wbuf[i0];
    if (t >= IW'(16))
      w_new = sig1(wbuf[i2]) + wbuf[i7] + sig0(wbuf[i15]) + wbuf[i0];
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE: if (enable) state_next = ST_LOAD;
      ST_LOAD: state_next = enable ? ST_RUN : ST_IDLE;
      ST_RUN: begin
        if (!enable)   state_next = ST_IDLE;
        else if (last) state_next = ST_DONE;
      end
      ST_DONE: if (!enable) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Any path back to IDLE (abort or release from DONE) clears every output.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      t                 <= '0;
      cur_w             <= '0;
      cur_k             <= '0;
      wk_vector_index   <= '0;
      wk_valid          <= 1'b0;
      wk_index_complete <= 1'b0;
    end else if (state_next == ST_IDLE) begin
      t                 <= '0;
      cur_w             <= '0;
      cur_k             <= '0;
      wk_vector_index   <= '0;
      wk_valid          <= 1'b0;
      wk_index_complete <= 1'b0;
    end else if (state == ST_LOAD) begin
      t <= '0;
    end else if (state == ST_RUN) begin
      cur_w             <= w_new;
      cur_k             <= k_t;
      wk_vector_index   <= t;
      wk_valid          <= 1'b1;
      wk_index_complete <= last;
      if (!last) t <= t + IW'(1);
    end else if (state == ST_DONE) begin
      wk_valid <= 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (state == ST_LOAD) begin
      for (int unsigned i = 0; i < 16; i++)
        wbuf[i] <= message_block[511 - 32*i -: 32];
    end else if (state == ST_RUN && t >= IW'(16)) begin
      wbuf[i0] <= w_new;
    end
  end

endmodule
